// File: rtl/gpio_event_pkg.sv
// Shared types for the GPIO event controller: per-pin trigger encoding,
// event channel state and a helper that classifies edge trigger types.
package gpio_event_pkg;

  // Per-pin trigger type. Codes 6 and 7 are reserved and never trigger.
  typedef enum logic [2:0] {
    DIS  = 3'd0,
    RISE = 3'd1,
    FALL = 3'd2,
    BOTH = 3'd3,
    HIGH = 3'd4,
    LOW  = 3'd5
  } irq_type_e;

  // Event channel state.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    VALID = 1'b1
  } evt_state_e;

  // True for trigger types that fire on edge pulses rather than levels.
  function automatic logic is_edge_type(input logic [2:0] t);
    return (t == RISE) || (t == FALL) || (t == BOTH);
  endfunction

endpackage

// File: rtl/gpio_event_ctrl_rr_arb.sv
// Combinational round-robin pick: returns the first requesting index at or
// after the pointer, wrapping modulo NrGpios.
module gpio_event_rr_arb
  import gpio_event_pkg::*;
#(
  parameter  int NrGpios = 32,
  localparam int IdWidth = $clog2(NrGpios)
) (
  input  logic [NrGpios-1:0] req,
  input  logic [IdWidth-1:0] pointer,
  output logic [IdWidth-1:0] gnt_id,
  output logic               gnt_valid
);

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    int idx;
    idx       = 0;
    gnt_id    = '0;
    gnt_valid = 1'b0;
    for (int i = NrGpios - 1; i >= 0; i--) begin
      idx = int'(pointer) + i;
      if (idx >= NrGpios) idx = idx - NrGpios;
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_id    = IdWidth'(idx);
      end
    end
  end

endmodule

// File: rtl/gpio_event_ctrl.sv
// GPIO event controller: qualifies input-stage edges/levels per pin, latches
// pending status, raises one aggregated interrupt and serialises pending pins
// onto a valid/ready event channel via a round-robin arbiter.
// Optional: define GPIO_EVT_OVERFLOW_EN to add the per-pin ovf_o flags that
// record a second edge hit arriving while the pin is still pending.
module gpio_event_ctrl
  import gpio_event_pkg::*;
#(
  parameter  int NrGpios = 32,
  localparam int IdWidth = $clog2(NrGpios)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NrGpios-1:0]      r_edge_i,
  input  logic [NrGpios-1:0]      f_edge_i,
  input  logic [NrGpios-1:0]      level_i,
  input  logic [NrGpios-1:0]      irq_en_i,
  input  logic [NrGpios-1:0][2:0] irq_type_i,
  input  logic                    clr_valid_i,
  input  logic [NrGpios-1:0]      clr_mask_i,
  output logic [NrGpios-1:0]      gpio_en_o,
  output logic [NrGpios-1:0]      status_o,
  output logic                    irq_o,
`ifdef GPIO_EVT_OVERFLOW_EN
  output logic [NrGpios-1:0]      ovf_o,
`endif
  output logic                    evt_valid_o,
  output logic [IdWidth-1:0]      evt_id_o,
  input  logic                    evt_ready_i
);

  logic [NrGpios-1:0] hit;
  logic [NrGpios-1:0] clr;
  logic [NrGpios-1:0] status_next;
  logic [NrGpios-1:0] sent;
  logic [NrGpios-1:0] sent_set;
  logic [NrGpios-1:0] req;
  logic [IdWidth-1:0] rr_ptr;
  logic [IdWidth-1:0] gnt_id;
  logic               gnt_valid;
  logic               handshake;
  evt_state_e         state;

  assign gpio_en_o   = irq_en_i;
  assign clr         = {NrGpios{clr_valid_i}} & clr_mask_i;
  assign status_next = hit | (status_o & ~clr);
  assign req         = status_o & ~sent & irq_en_i;
  assign handshake   = evt_valid_o & evt_ready_i;

  // Qualify each stage's edge/level outputs against its trigger type.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NrGpios; i++) begin
      if (irq_en_i[i]) begin
        case (irq_type_i[i])
          RISE:    hit[i] = r_edge_i[i];
          FALL:    hit[i] = f_edge_i[i];
          BOTH:    hit[i] = r_edge_i[i] | f_edge_i[i];
          HIGH:    hit[i] = level_i[i];
          LOW:     hit[i] = ~level_i[i];
          default: hit[i] = 1'b0;
        endcase
      end
    end
  end

  // Mark the emitted pin as sent, unless it was cleared before or during the beat.
  always_comb begin
    sent_set = '0;
    if (handshake) sent_set[evt_id_o] = status_o[evt_id_o] & ~clr[evt_id_o];
  end

  gpio_event_rr_arb #(
    .NrGpios (NrGpios)
  ) u_arb (
    .req       (req),
    .pointer   (rr_ptr),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  // Pending status, sent flags and the aggregated interrupt.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      status_o <= '0;
      sent     <= '0;
      irq_o    <= 1'b0;
    end else begin
      status_o <= status_next;
      sent     <= (sent | sent_set) & ~clr;
      irq_o    <= |status_next;
    end
  end

  // Event channel: load a grant in IDLE, hold it until accepted, then idle a cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      evt_valid_o <= 1'b0;
      evt_id_o    <= '0;
      rr_ptr      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            evt_id_o    <= gnt_id;
            evt_valid_o <= 1'b1;
            state       <= VALID;
          end
        end
        VALID: begin
          if (evt_ready_i) begin
            evt_valid_o <= 1'b0;
            rr_ptr      <= (evt_id_o == IdWidth'(NrGpios - 1)) ? '0 : evt_id_o + IdWidth'(1);
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GPIO_EVT_OVERFLOW_EN
  logic [NrGpios-1:0] ovf_set;

  // An edge hit on an already-pending pin means an event was merged.
  always_comb begin
    ovf_set = '0;
    for (int i = 0; i < NrGpios; i++) begin
      ovf_set[i] = hit[i] & status_o[i] & is_edge_type(irq_type_i[i]);
    end
  end

  // Overflow flags share the status clear path; a clear beats a same-cycle set.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ovf_o <= '0;
    else         ovf_o <= (ovf_o | ovf_set) & ~clr;
  end
`endif

endmodule

// File: tb/tb_gpio_event_ctrl.sv
// Bench for gpio_event_ctrl (NrGpios=8): directed scenarios followed by
// randomized stimulus, all checked cycle by cycle against a behavioural model.
module tb_gpio_event_ctrl;

  localparam int N  = 8;
  localparam int IW = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      r_edge, f_edge, level, irq_en, clr_mask;
  logic [N-1:0][2:0] irq_type;
  logic              clr_valid, evt_ready;
  logic [N-1:0]      gpio_en, status;
  logic              irq, evt_valid;
  logic [IW-1:0]     evt_id;
`ifdef GPIO_EVT_OVERFLOW_EN
  logic [N-1:0]      ovf;
`endif

  gpio_event_ctrl #(.NrGpios(N)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .r_edge_i    (r_edge),
    .f_edge_i    (f_edge),
    .level_i     (level),
    .irq_en_i    (irq_en),
    .irq_type_i  (irq_type),
    .clr_valid_i (clr_valid),
    .clr_mask_i  (clr_mask),
    .gpio_en_o   (gpio_en),
    .status_o    (status),
    .irq_o       (irq),
`ifdef GPIO_EVT_OVERFLOW_EN
    .ovf_o       (ovf),
`endif
    .evt_valid_o (evt_valid),
    .evt_id_o    (evt_id),
    .evt_ready_i (evt_ready)
  );

  always #5 clk = ~clk;

  // Reference model state.
  bit [N-1:0] m_status, m_sent, m_ovf;
  bit         m_irq, m_valid;
  int         m_id, m_ptr;
  int         evlog[$];
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit trig(input int i);
    if (!irq_en[i]) return 1'b0;
    case (int'(irq_type[i]))
      1:       return r_edge[i];
      2:       return f_edge[i];
      3:       return r_edge[i] | f_edge[i];
      4:       return level[i];
      5:       return !level[i];
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_status = '0; m_sent = '0; m_ovf = '0;
    m_irq = 0; m_valid = 0; m_id = 0; m_ptr = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit [N-1:0] hit, clr, ns, nsent, novf;
    int t;
    for (int i = 0; i < N; i++) begin
      hit[i] = trig(i);
      clr[i] = clr_valid && clr_mask[i];
      ns[i]  = hit[i] || (m_status[i] && !clr[i]);
      nsent[i] = m_sent[i];
      if (m_valid && evt_ready && i == m_id && m_status[i]) nsent[i] = 1;
      if (clr[i]) nsent[i] = 0;
      t = int'(irq_type[i]);
      novf[i] = (m_ovf[i] || (hit[i] && m_status[i] && t >= 1 && t <= 3)) && !clr[i];
    end
    if (m_valid) begin
      if (evt_ready) begin
        evlog.push_back(m_id);
        m_valid = 0;
        m_ptr   = (m_id + 1) % N;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (m_status[idx] && !m_sent[idx] && irq_en[idx]) begin
          m_valid = 1;
          m_id    = idx;
          break;
        end
      end
    end
    m_status = ns;
    m_sent   = nsent;
    m_ovf    = novf;
    m_irq    = |ns;
  endtask

  task automatic compare();
    chk("status", status, m_status);
    chk("irq", irq, m_irq);
    chk("evt_valid", evt_valid, m_valid);
    chk("evt_id", evt_id, m_id);
    chk("gpio_en", gpio_en, irq_en);
`ifdef GPIO_EVT_OVERFLOW_EN
    chk("ovf", ovf, m_ovf);
`endif
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic quiet();
    r_edge = '0; f_edge = '0; clr_valid = 0; clr_mask = '0;
  endtask

  task automatic clear_all();
    clr_valid = 1; clr_mask = '1;
    tick();
    quiet();
  endtask

  int cnt;

  initial begin
    rst_n = 0; quiet(); level = '0; irq_en = '0; irq_type = '0; evt_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare();
    chk("reset_status", status, 0);
    chk("reset_valid", evt_valid, 0);
    rst_n = 1;

    // Pin 3 rising edge, ready held low for a while.
    irq_en = 8'h08; irq_type[3] = 3'd1;
    r_edge[3] = 1;
    tick();
    chk("s1_status", status, 8'h08);
    chk("s1_irq", irq, 1);
    r_edge[3] = 0;
    tick();
    chk("s1_valid", evt_valid, 1);
    chk("s1_id", evt_id, 3);
    repeat (4) begin
      tick();
      chk("s1_hold_valid", evt_valid, 1);
      chk("s1_hold_id", evt_id, 3);
    end
    evt_ready = 1;
    tick();
    chk("s1_drop", evt_valid, 0);
    repeat (4) tick();
    chk("s1_no_reemit", evlog.size(), 1);
    clear_all();

    // Emit pin 7 first so the pointer wraps to 0.
    irq_en = 8'h80; irq_type[7] = 3'd1;
    r_edge[7] = 1; tick(); quiet();
    repeat (5) tick();
    clear_all();
    evlog.delete();

    // Pins 1, 5, 6 simultaneously, ready always high.
    irq_en = 8'h62; irq_type[1] = 3'd1; irq_type[5] = 3'd1; irq_type[6] = 3'd1;
    r_edge = 8'h62; tick(); quiet();
    repeat (10) tick();
    chk("s2_count", evlog.size(), 3);
    if (evlog.size() == 3) begin
      chk("s2_ev0", evlog[0], 1);
      chk("s2_ev1", evlog[1], 5);
      chk("s2_ev2", evlog[2], 6);
    end
    clr_valid = 1; clr_mask = 8'h62; tick(); quiet();
    irq_en = 8'h01; irq_type[0] = 3'd1;
    r_edge[0] = 1; tick(); quiet();
    repeat (5) tick();
    chk("s2_wrap", evlog.size() > 0 ? evlog[evlog.size()-1] : -1, 0);
    clear_all();

    // Pin 2 level-high: clears do not stick while the level persists.
    irq_en = 8'h04; irq_type[2] = 3'd4; level[2] = 1;
    repeat (2) tick();
    clr_valid = 1; clr_mask = 8'h04; tick(); quiet();
    chk("s3_hold", status[2], 1);
    level[2] = 0; tick();
    clr_valid = 1; clr_mask = 8'h04; tick(); quiet();
    chk("s3_status", status, 0);
    chk("s3_irq", irq, 0);

    // Pin 4 falling edge with same-cycle clear; then disable the pin.
    irq_en = 8'h10; irq_type[4] = 3'd2;
    f_edge[4] = 1; clr_valid = 1; clr_mask = 8'h10; tick(); quiet();
    chk("s4_hit_wins", status[4], 1);
    repeat (4) tick();
    irq_en = 8'h00;
    f_edge[4] = 1; tick(); quiet();
    tick();
    chk("s4_status_kept", status[4], 1);
    chk("s4_gpio_en", gpio_en[4], 0);
    clear_all();

    // Async reset while a beat is outstanding on id 6.
    evt_ready = 0; irq_en = 8'h40; irq_type[6] = 3'd1;
    r_edge[6] = 1; tick(); quiet();
    tick();
    chk("s5_valid", evt_valid, 1);
    chk("s5_id", evt_id, 6);
    #2 rst_n = 0;
    model_reset();
    #1;
    compare();
    chk("s5_async_valid", evt_valid, 0);
    @(posedge clk); #3 rst_n = 1;
    @(negedge clk);
    evt_ready = 1;
    repeat (4) tick();
    chk("s5_no_event", evt_valid, 0);

`ifdef GPIO_EVT_OVERFLOW_EN
    // Two rising pulses on pin 7 without a clear.
    evlog.delete();
    evt_ready = 0; irq_en = 8'h80; irq_type[7] = 3'd1;
    r_edge[7] = 1; tick(); quiet(); tick();
    r_edge[7] = 1; tick(); quiet();
    chk("s6_ovf", ovf, 8'h80);
    evt_ready = 1;
    repeat (6) tick();
    chk("s6_single", evlog.size(), 1);
    clr_valid = 1; clr_mask = 8'h80; tick(); quiet();
    chk("s6_ovf_clr", ovf, 0);
`endif

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      if (n % 50 == 0) begin
        irq_en = N'($urandom);
        for (int i = 0; i < N; i++) irq_type[i] = 3'($urandom_range(0, 7));
      end
      r_edge    = N'($urandom & $urandom & $urandom);
      f_edge    = N'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 7) == 0) level = N'($urandom);
      clr_valid = ($urandom_range(0, 5) == 0);
      clr_mask  = N'($urandom);
      evt_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    quiet();
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gpio_event_ctrl.md
Name: gpio_event_ctrl

Overview:
- Interrupt/event controller for a bank of NrGpios GPIO input stages.
- Drives each stage's enable.
- Qualifies each stage's rise/fall/level outputs against a per-pin trigger type and latches per-pin pending status.
- Raises one aggregated interrupt, and serialises pending pins onto a single valid/ready event channel (to the event unit or uDMA) through a round-robin arbiter.

Parameters:
- NrGpios, 32, number of GPIO pins/input stages; legal range 2..64.
- IdWidth, $clog2(NrGpios), width of the event pin index (derived, not overridden).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- r_edge_i  in  NrGpios  rising-edge pulses from input stages
- f_edge_i  in  NrGpios  falling-edge pulses from input stages
- level_i  in  NrGpios  synchronised pin levels from input stages
- irq_en_i  in  NrGpios  per-pin interrupt enable (config reg)
- irq_type_i  in  NrGpios x 3  per-pin trigger type (irq_type_e)
- clr_valid_i  in  1  status clear strobe
- clr_mask_i  in  NrGpios  pins cleared when clr_valid_i=1
- gpio_en_o  out  NrGpios  input stage enable = irq_en_i (combinational)
- status_o  out  NrGpios  pending register
- irq_o  out  1  OR of status_o (registered)
- evt_valid_o  out  1  event channel valid
- evt_id_o  out  IdWidth  pin index of event
- evt_ready_i  in  1  event channel ready

Behaviour:
- Reset (async, rst_ni low): status_o=0, sent=0, irq_o=0, evt_valid_o=0, evt_id_o=0, rr pointer=0.
- Trigger hit[i], combinational, only if irq_en_i[i]=1:
  - RISE: r_edge_i
  - FALL: f_edge_i
  - BOTH: r_edge_i | f_edge_i
  - HIGH: level_i
  - LOW: !level_i
  - DIS or reserved codes: 0
- Pending register:
  - status[i] <= hit[i] | (status[i] & !(clr_valid_i & clr_mask_i[i])).
  - A hit and a clear in the same cycle leave the bit set; no event is lost.
  - Level types re-set every cycle while the level persists.
- Clearing irq_en_i[i] does not clear status[i]; it blocks new hits and excludes the pin from arbitration.
- irq_o <= |status (next-state value). A hit in cycle t gives status and irq_o high at t+1.
- sent[i] marks pins already emitted on the channel.
  - sent[i] is set on handshake for that id.
  - sent[i] is cleared whenever status[i] is cleared.
  - A new hit on a pin with sent=1 does not re-emit it until software clears the pin.
- Arbiter request vector: req = status & ~sent & irq_en_i. Grant is the first requesting index at or after rr pointer, wrapping modulo NrGpios.
- Channel FSM:
  - IDLE: if req != 0, load evt_id_o = grant and evt_valid_o = 1, go to VALID. With a hit at t, evt_valid_o first rises at t+2.
  - VALID: evt_id_o and evt_valid_o stay stable until evt_ready_i=1.
  - On handshake: sent[id] set; rr pointer = id+1, wrapping at NrGpios-1 to 0; go to IDLE. At least one IDLE cycle follows, so there are no back-to-back beats.
  - If the pending pin is cleared while in VALID, the beat still completes (AXI-style, no retraction) and sent is not set for the cleared pin.
- Simultaneous handshake and clear of the same pin: the clear wins; sent stays 0.

Optional Feature:
- Macro GPIO_EVT_OVERFLOW_EN.
- When defined:
  - Adds output ovf_o[NrGpios]. ovf[i] is set when hit[i] arrives while status[i]=1 and irq_type_i[i] is an edge type (RISE/FALL/BOTH).
  - ovf[i] is cleared together with status[i] through clr_mask_i; a same-cycle hit and clear leave ovf=0.
  - ovf_o resets to 0.
- When undefined: no ovf_o port and no ovf logic.

Decomposition:
- Package gpio_event_pkg:
  - irq_type_e (3 bits): DIS=0, RISE=1, FALL=2, BOTH=3, HIGH=4, LOW=5.
  - Channel state enum evt_state_e: IDLE, VALID.
- Sub-module gpio_event_rr_arb:
  - Purely combinational round-robin priority pick.
  - Inputs: req, pointer. Outputs: gnt_id, gnt_valid.
  - Parameter: NrGpios.

Test Plan (NrGpios=8):
- Pin 3, RISE, enabled; r_edge_i[3] pulses at t. Expect:
  - status_o=0x08 and irq_o=1 at t+1.
  - evt_valid_o=1 with evt_id_o=3 at t+2.
  - Hold ready=0 for 4 cycles: id and valid stay stable.
  - After ready=1, valid drops; no re-emit.
- Pins 1, 5, 6 hit in the same cycle with rr pointer=0 and ready=1 throughout. Expect:
  - Ids 1, 5, 6 in order, each separated by one idle cycle.
  - rr pointer ends at 7. A later hit on pin 0 then emits id 0 (wrap).
- Pin 2 set to HIGH with level_i[2]=1 held; clr_valid_i/clr_mask_i=0x04 pulsed. Expect status[2] to stay 1. Drop the level and clear again: status=0, irq_o=0 next cycle.
- Pin 4 FALL: f_edge_i[4] and clr with mask 0x10 in the same cycle. Expect status[4]=1. Disable irq_en_i[4] and pulse f_edge_i again: no change, and gpio_en_o[4]=0.
- Reset asserted while evt_valid_o=1 with id=6. Expect all outputs 0 asynchronously and no event after release.
- With GPIO_EVT_OVERFLOW_EN: two rise pulses on pin 7 with no clear. Expect ovf_o=0x80 and a single event id 7. After clr mask 0x80, ovf_o=0.
